fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 16-deep, 8-bit FIFO buffer between NUM_REQ independent producers. Each grant covers a burst of up to BURST_MAX words. The block sits directly in front of the FIFO write interface: it drives the FIFO's `wr_en` and `data` inputs and observes the FIFO's `full_o` output. When the FIFO is full, requesters are stalled. No data is ever dropped.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and default constants for the FIFO write-port arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, BURST)
//   NUM_REQ_DEF    : default number of requesters
//   DATA_W_DEF     : default word width (matches the FIFO data width)
//   BURST_MAX_DEF  : default maximum words per grant
//   STALL_CNT_W    : width of the optional stall statistics counter
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int BURST_MAX_DEF = 4;
    localparam int STALL_CNT_W   = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder. Searches req_valid_i upward
// starting at rr_ptr_i, wrapping from N-1 back to 0, and returns the first
// set index.
//   req_valid_i : per-requester request bits
//   rr_ptr_i    : index where the search starts (highest priority)
//   idx_o       : index of the winning requester (0 when none found)
//   found_o     : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_valid_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            int c;
            // Explicit wrap keeps the candidate in range for non-power-of-2 N.
            c = int'(rr_ptr_i) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!found_o && req_valid_i[c]) begin
                found_o = 1'b1;
                idx_o   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant is a burst of up to BURST_MAX words; a full FIFO stalls the
// current owner without ending the burst, so no word is ever dropped.
// Every burst is preceded by a one-cycle arbitration bubble in IDLE.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-requester "word available"
//   req_data    : packed requester words, requester i at [i*DATA_W +: DATA_W]
//   req_gnt     : one-hot word-accept strobe (combinational)
//   fifo_full   : FIFO full flag
//   fifo_wr_en  : FIFO write enable (combinational, never while full)
//   fifo_data   : FIFO write data (zero outside an accept)
//   busy        : burst in progress
//   owner       : current or most recent burst owner
//   stall_clr   : (FIFO_WR_ARB_STATS_EN only) synchronous stall counter clear
//   stall_cnt   : (FIFO_WR_ARB_STATS_EN only) saturating stall-cycle counter
//
// Build option: define FIFO_WR_ARB_STATS_EN to add the stall statistics.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_gnt,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic                       stall_clr,
    output logic [STALL_CNT_W-1:0]     stall_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_MAX - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    arb_state_e    state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] rr_ptr_d;
    logic [CW-1:0] burst_cnt_q;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          own_valid;
    logic          accept;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .idx_o       (pick_idx),
        .found_o     (pick_found)
    );

    assign own_valid = req_valid[owner_q];
    // Gating with fifo_full here is what guarantees a write is never rejected.
    assign accept    = (state_q == BURST) && own_valid && !fifo_full;
    // Next search starts just past the finishing owner.
    assign rr_ptr_d  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q     <= pick_idx;
                        burst_cnt_q <= '0;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        if (burst_cnt_q == LAST_CNT) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end else if (!own_valid) begin
                        // Owner withdrew; a full FIFO alone never lands here.
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_gnt    = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        if (accept) begin
            req_gnt[owner_q] = 1'b1;
            fifo_wr_en       = 1'b1;
            fifo_data        = req_data[int'(owner_q)*DATA_W +: DATA_W];
        end
    end

    assign busy  = (state_q == BURST);
    assign owner = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   stall_hit;

    assign stall_hit = (state_q == BURST) && own_valid && fifo_full;

    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_cnt_q <= '0;
        end else if (stall_hit && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (4 requesters, 8-bit words, bursts of 4).
// Each requester presents a word that advances when it is granted; expected
// FIFO writes are queued as stimulus is set up and popped on every write.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    typedef struct {
        int         r;
        logic [7:0] d;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_gnt;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic            busy;
    logic [1:0]      owner;
`ifdef FIFO_WR_ARB_STATS_EN
    logic            stall_clr;
    logic [15:0]     stall_cnt;
`endif

    logic [7:0] word     [NR];
    logic [7:0] exp_word [NR];
    exp_t       sb[$];
    int         total;
    int         bad;
    logic       s_wr;
    logic       s_busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .BURST_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_gnt    (req_gnt),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .owner      (owner)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_clr  (stall_clr),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = word[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int r, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.r = r;
            e.d = exp_word[r];
            sb.push_back(e);
            exp_word[r] = exp_word[r] + 8'd1;
        end
    endtask

    // One clock cycle: check the presented write mid-cycle, then let the
    // granted requester move to its next word just after the edge.
    task automatic tick();
        logic [NR-1:0] g;
        exp_t e;
        @(negedge clk);
        g      = req_gnt;
        s_wr   = fifo_wr_en;
        s_busy = busy;
        chk("wr_while_full", {31'd0, fifo_wr_en & fifo_full}, 32'd0);
        if (fifo_wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {24'd0, fifo_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("gnt", {28'd0, req_gnt}, 32'd1 << e.r);
                chk("data", {24'd0, fifo_data}, {24'd0, e.d});
            end
        end else begin
            chk("idle_gnt", {28'd0, req_gnt}, 32'd0);
            chk("idle_data", {24'd0, fifo_data}, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) word[i] = word[i] + 8'd1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < NR; i++) begin
            word[i]     = 8'(i * 16);
            exp_word[i] = 8'(i * 16);
        end
        rst       = 1'b1;
        req_valid = '1;
        fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stall_clr = 1'b0;
`endif
        @(posedge clk);
        #1;

        // Reset held with every requester valid.
        repeat (2) begin
            tick();
            chk("rst_wr_en", {31'd0, s_wr}, 32'd0);
            chk("rst_busy", {31'd0, s_busy}, 32'd0);
            chk("rst_owner", {30'd0, owner}, 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("rel_owner", {30'd0, owner}, 32'd0);
        chk("rel_busy", {31'd0, busy}, 32'd1);

        // Fairness: 4 words each from 0,1,2,3 then 0 again, one bubble between.
        push_burst(0, 4);
        push_burst(1, 4);
        push_burst(2, 4);
        push_burst(3, 4);
        push_burst(0, 4);
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk("fair_wr", {31'd0, s_wr}, {31'd0, ((c % 5) != 0)});
            chk("fair_busy", {31'd0, s_busy}, {31'd0, ((c % 5) != 0)});
        end

        // Early release: requester 2 offers two words then withdraws.
        req_valid   = 4'b0100;
        word[2]     = 8'hA1;
        exp_word[2] = 8'hA1;
        push_burst(2, 2);
        tick();
        chk("er_bubble", {31'd0, s_wr}, 32'd0);
        tick();
        tick();
        req_valid = 4'b0000;
        tick();
        chk("er_nowr", {31'd0, s_wr}, 32'd0);
        chk("er_busy_last", {31'd0, s_busy}, 32'd1);
        chk("er_idle", {31'd0, busy}, 32'd0);
        req_valid = 4'b1001;
        tick();
        chk("er_bubble2", {31'd0, s_wr}, 32'd0);
        chk("er_next_owner", {30'd0, owner}, 32'd3);
        push_burst(3, 4);
        repeat (4) tick();
        chk("r3_done", {31'd0, busy}, 32'd0);

        // Backpressure: FIFO full for 5 cycles inside requester 1's burst.
        req_valid = 4'b0010;
        push_burst(1, 4);
        tick();
        chk("bp_owner", {30'd0, owner}, 32'd1);
        tick();
        tick();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_stall_wr", {31'd0, s_wr}, 32'd0);
            chk("bp_stall_busy", {31'd0, s_busy}, 32'd1);
        end
        fifo_full = 1'b0;
        tick();
        chk("bp_resume_wr", {31'd0, s_wr}, 32'd1);
        tick();
        chk("bp_done", {31'd0, busy}, 32'd0);
        req_valid = 4'b0000;
        tick();
        chk("bp_quiet", {31'd0, s_wr}, 32'd0);

        // Reset in the middle of a requester 0 burst.
        req_valid = 4'b0001;
        push_burst(0, 2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_owner", {30'd0, owner}, 32'd0);
        rst       = 1'b0;
        req_valid = 4'b1001;
        tick();
        chk("mr_bubble", {31'd0, s_wr}, 32'd0);
        chk("mr_rrptr0", {30'd0, owner}, 32'd0);
        push_burst(0, 1);
        tick();
        chk("mr_new_wr", {31'd0, s_wr}, 32'd1);
        req_valid = 4'b0000;
        tick();
        chk("mr_end_wr", {31'd0, s_wr}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

`ifdef FIFO_WR_ARB_STATS_EN
        // Stall statistics: count, clear, saturate.
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("st_clr0", {16'd0, stall_cnt}, 32'd0);
        req_valid = 4'b0001;
        fifo_full = 1'b1;
        tick();
        repeat (300) tick();
        chk("st_300", {16'd0, stall_cnt}, 32'd300);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("st_clr", {16'd0, stall_cnt}, 32'd0);
        repeat (70000) @(posedge clk);
        #1;
        chk("st_sat", {16'd0, stall_cnt}, 32'd65535);
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        tick();
        chk("st_exit_wr", {31'd0, s_wr}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
